store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable store-stream monitor that sits directly downstream of the single-cycle RISC-V `top`. It consumes the core's data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and produces registered run verdicts: pass on a designated store, fail on an illegal store, timeout on no verdict. It also exposes store/cycle counters and a 4-deep history of recent stores for FPGA bring-up and self-checking simulation.

## Interface
- `PASS_ADDR`, 32'd216: store address that signals test completion.
- `PASS_DATA`, 32'd4140: data value required at `PASS_ADDR` for a pass.
- `WIN_LO`, 32'd0: lowest legal store address, inclusive.
- `WIN_HI`, 32'd255: highest legal store address, inclusive.
- `TIMEOUT_CYCLES`, 32'd10000: RUN-state cycle budget; must be ≥ 2.
- `clk`  in  1  rising-edge clock, shared with `top`.
- `reset`  in  1  synchronous, active-low reset; 0 resets on the next rising edge of `clk`.
- `MemWrite`  in  1  store strobe from core.
- `DataAdr`  in  32  store byte address.
- `WriteData`  in  32  store data.
- `hist_sel`  in  2  history read index; 0 is the most recent store.
- `done`  out  1  verdict reached (pass | fail | timeout).
- `pass`  out  1  pass verdict.
- `fail`  out  1  illegal-store verdict.
- `timeout`  out  1  cycle budget exhausted.
- `store_count`  out  16  accepted stores; saturates at 16'hFFFF.
- `cycle_count`  out  32  cycles spent in RUN.
- `hist_valid`  out  3  number of valid history entries, 0..4.
- `hist_adr`  out  32  address of history entry `hist_sel`.
- `hist_data`  out  32  data of history entry `hist_sel`.

## Operation
- FSM states: RUN, PASS, FAIL, TOUT. Reset enters RUN. PASS, FAIL and TOUT are terminal and sticky until reset.
- In RUN, a store is a rising edge with `MemWrite`=1. It is classified with this priority:
  1. pass-match: `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA`. Go to PASS.
  2. illegal: `DataAdr[1:0]`≠0, or `DataAdr`<`WIN_LO`, or `DataAdr`>`WIN_HI`, or (`DataAdr`==`PASS_ADDR` and data mismatch). Go to FAIL.
  3. otherwise legal. Stay in RUN.
- Every store seen in RUN, including the verdict store, increments `store_count` (saturating) and is pushed into history.
- Timeout: in RUN with no store classified as pass or illegal, if `cycle_count`==`TIMEOUT_CYCLES`-1, go to TOUT. A pass or fail event in that same cycle takes precedence over timeout.
- `cycle_count` increments by 1 on every RUN cycle and freezes on leaving RUN.
- In terminal states, stores are ignored: no count, no history push, no state change.
- History is a 4-entry circular buffer with a 2-bit write pointer that wraps 3→0.
  - `hist_adr`/`hist_data` are combinational reads of entry (wptr-1-`hist_sel`) mod 4.
  - Entries at or beyond `hist_valid` read as 0.
  - `hist_valid` increments per push and saturates at 4.
- Address comparisons are unsigned 32-bit.

## Timing
- Reset values, after the first rising edge with `reset`=0: `done`=`pass`=`fail`=`timeout`=0, `store_count`=0, `cycle_count`=0, `hist_valid`=0, write pointer=0, all history entries 0, state RUN.
- Reset mid-run or in a terminal state has the same effect on the next edge. Stores presented during a reset edge are discarded.
- `done`, `pass`, `fail`, `timeout` and the counters are registered. A store sampled at edge N updates them after edge N, so they are visible in cycle N+1 (one-cycle latency).
- `done` is the OR of the three verdict flags, registered in the same edge as the flag. At most one verdict flag is ever 1.
- Back-to-back stores, one per cycle, are all accepted. There is no stall or backpressure.
- `cycle_count` reads `TIMEOUT_CYCLES`-1 in the cycle that `timeout` rises.

## Test plan
- Reset, then one store (216, 4140) at the first RUN edge -> `pass`=`done`=1 next cycle, `store_count`=1, `hist_adr`(sel 0)=216, `hist_data`=4140.
- Stores (96,7), (100,25), (216,4140) on consecutive cycles -> `pass`=1 after the third edge, `store_count`=3, history sel 0/1/2 = 216/100/96, `hist_valid`=3.
- Store (300,1) -> `fail`=1, `pass`=0. A later store (216,4140) leaves `fail`=1 and `store_count`=1. Store (102,0) in a fresh run -> `fail`=1 (misaligned). Store (216,5) in a fresh run -> `fail`=1.
- `TIMEOUT_CYCLES`=20 with no stores -> `timeout`=1 after the 20th RUN edge, `cycle_count`=19. Store (216,4140) on that same edge -> `pass`=1, `timeout`=0.
- Six legal stores to addresses 0,4,8,12,16,20 -> `hist_valid`=4; sel 0..3 = 20,16,12,8 (wrap verified); `store_count`=6.
- Three legal stores, then `reset`=0 for one edge concurrent with `MemWrite`=1 -> all outputs 0, `hist_valid`=0; the store is not counted.

Source files
------------

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : store_monitor
//  Purpose  : Watches the core's store port and latches a pass / fail /
//             timeout verdict, with store and cycle counters and a 4-deep
//             history of recent stores.
//  Revision : 1.0 - initial release
// ============================================================================
module store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd216,
    parameter logic [31:0] PASS_DATA      = 32'd4140,
    parameter logic [31:0] WIN_LO         = 32'd0,
    parameter logic [31:0] WIN_HI         = 32'd255,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  hist_sel,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic [2:0]  hist_valid,
    output logic [31:0] hist_adr,
    output logic [31:0] hist_data
);

    localparam logic [1:0]  c_S_RUN     = 2'd0;
    localparam logic [1:0]  c_S_PASS    = 2'd1;
    localparam logic [1:0]  c_S_FAIL    = 2'd2;
    localparam logic [1:0]  c_S_TOUT    = 2'd3;
    localparam logic [31:0] c_TOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    logic [1:0]  r_state;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [15:0] r_store_count;
    logic [31:0] r_cycle_count;
    logic [2:0]  r_hist_valid;
    logic [1:0]  r_wptr;
    logic [31:0] r_hist_adr  [4];
    logic [31:0] r_hist_data [4];

    logic        w_store;
    logic        w_is_pass_adr;
    logic        w_pass_hit;
    logic        w_illegal;
    logic        w_tout;
    logic [32:0] w_lo_diff;
    logic [32:0] w_hi_diff;
    logic [1:0]  w_rd_idx;

    // Window bounds are checked through the borrow of a 33-bit subtraction,
    // which stays meaningful even when a bound sits at 0 or all-ones.
    assign w_lo_diff     = {1'b0, DataAdr} - {1'b0, WIN_LO};
    assign w_hi_diff     = {1'b0, WIN_HI} - {1'b0, DataAdr};

    assign w_store       = MemWrite && (r_state == c_S_RUN);
    assign w_is_pass_adr = (DataAdr == PASS_ADDR);
    assign w_pass_hit    = w_store && w_is_pass_adr && (WriteData == PASS_DATA);
    assign w_illegal     = w_store && !w_pass_hit &&
                           ((DataAdr[1:0] != 2'd0) || w_lo_diff[32] ||
                            w_hi_diff[32] || w_is_pass_adr);
    assign w_tout        = (r_state == c_S_RUN) && !w_pass_hit && !w_illegal &&
                           (r_cycle_count == c_TOUT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_S_RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_store_count <= 16'd0;
            r_cycle_count <= 32'd0;
            r_hist_valid  <= 3'd0;
            r_wptr        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_hist_adr[i]  <= 32'd0;
                r_hist_data[i] <= 32'd0;
            end
        end else begin
            if (w_store) begin
                if (r_store_count != 16'hFFFF) begin
                    r_store_count <= r_store_count + 16'd1;
                end
                r_hist_adr[r_wptr]  <= DataAdr;
                r_hist_data[r_wptr] <= WriteData;
                r_wptr              <= r_wptr + 2'd1;
                if (r_hist_valid != 3'd4) begin
                    r_hist_valid <= r_hist_valid + 3'd1;
                end
            end
            // The cycle counter only advances on edges that stay in RUN, so it
            // holds TIMEOUT_CYCLES-1 once the timeout verdict is taken.
            if (r_state == c_S_RUN) begin
                if (w_pass_hit) begin
                    r_state <= c_S_PASS;
                    r_pass  <= 1'b1;
                    r_done  <= 1'b1;
                end else if (w_illegal) begin
                    r_state <= c_S_FAIL;
                    r_fail  <= 1'b1;
                    r_done  <= 1'b1;
                end else if (w_tout) begin
                    r_state   <= c_S_TOUT;
                    r_timeout <= 1'b1;
                    r_done    <= 1'b1;
                end else begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                end
            end
        end
    end

    assign w_rd_idx = r_wptr - 2'd1 - hist_sel;

    always_comb begin
        hist_adr  = 32'd0;
        hist_data = 32'd0;
        if ({1'b0, hist_sel} < r_hist_valid) begin
            hist_adr  = r_hist_adr[w_rd_idx];
            hist_data = r_hist_data[w_rd_idx];
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign store_count = r_store_count;
    assign cycle_count = r_cycle_count;
    assign hist_valid  = r_hist_valid;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_monitor
//  Purpose  : Directed self-checking bench for store_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_monitor;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [1:0]  hist_sel;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [31:0] cycle_count;
    logic [2:0]  hist_valid;
    logic [31:0] hist_adr;
    logic [31:0] hist_data;

    int n_total;
    int n_pass;

    store_monitor #(
        .PASS_ADDR      (32'd216),
        .PASS_DATA      (32'd4140),
        .WIN_LO         (32'd0),
        .WIN_HI         (32'd255),
        .TIMEOUT_CYCLES (32'd20)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .hist_sel    (hist_sel),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .store_count (store_count),
        .cycle_count (cycle_count),
        .hist_valid  (hist_valid),
        .hist_adr    (hist_adr),
        .hist_data   (hist_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        MemWrite = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic check_hist(input string tag, input logic [1:0] sel,
                              input logic [31:0] a, input logic [31:0] d);
        hist_sel = sel;
        #1;
        check({tag, "_adr"}, hist_adr, a);
        check({tag, "_data"}, hist_data, d);
    endtask

    task automatic check_flags(input string tag, input logic e_done, input logic e_pass,
                               input logic e_fail, input logic e_tout);
        check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, e_pass});
        check({tag, "_fail"}, {31'd0, fail}, {31'd0, e_fail});
        check({tag, "_tout"}, {31'd0, timeout}, {31'd0, e_tout});
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        hist_sel  = 2'd0;

        // Reset state, then an immediate pass store
        do_reset();
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_sc", {16'd0, store_count}, 32'd0);
        check("rst_cc", cycle_count, 32'd0);
        check("rst_hv", {29'd0, hist_valid}, 32'd0);
        check_hist("rst_h0", 2'd0, 32'd0, 32'd0);
        store(32'd216, 32'd4140);
        check_flags("p1", 1'b1, 1'b1, 1'b0, 1'b0);
        check("p1_sc", {16'd0, store_count}, 32'd1);
        check("p1_cc", cycle_count, 32'd0);
        check_hist("p1_h0", 2'd0, 32'd216, 32'd4140);

        // Legal stores followed by the pass store
        do_reset();
        store(32'd96, 32'd7);
        store(32'd100, 32'd25);
        check_flags("p3_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("p3_mid_sc", {16'd0, store_count}, 32'd2);
        store(32'd216, 32'd4140);
        check_flags("p3", 1'b1, 1'b1, 1'b0, 1'b0);
        check("p3_sc", {16'd0, store_count}, 32'd3);
        check("p3_hv", {29'd0, hist_valid}, 32'd3);
        check_hist("p3_h0", 2'd0, 32'd216, 32'd4140);
        check_hist("p3_h1", 2'd1, 32'd100, 32'd25);
        check_hist("p3_h2", 2'd2, 32'd96, 32'd7);
        check_hist("p3_h3", 2'd3, 32'd0, 32'd0);

        // Out-of-window store fails; terminal state ignores further stores
        do_reset();
        store(32'd300, 32'd1);
        check_flags("f_win", 1'b1, 1'b0, 1'b1, 1'b0);
        store(32'd216, 32'd4140);
        check_flags("f_sticky", 1'b1, 1'b0, 1'b1, 1'b0);
        check("f_sticky_sc", {16'd0, store_count}, 32'd1);
        check("f_sticky_hv", {29'd0, hist_valid}, 32'd1);
        check_hist("f_sticky_h0", 2'd0, 32'd300, 32'd1);

        do_reset();
        store(32'd102, 32'd0);
        check_flags("f_misal", 1'b1, 1'b0, 1'b1, 1'b0);

        do_reset();
        store(32'd216, 32'd5);
        check_flags("f_data", 1'b1, 1'b0, 1'b1, 1'b0);

        // Window edge: 252 is legal, 256 is just past WIN_HI
        do_reset();
        store(32'd252, 32'd9);
        check_flags("edge_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        store(32'd256, 32'd9);
        check_flags("edge_hi", 1'b1, 1'b0, 1'b1, 1'b0);

        // Timeout after the 20th RUN edge
        do_reset();
        for (int i = 0; i < 19; i++) tick();
        check_flags("t_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t_pre_cc", cycle_count, 32'd19);
        tick();
        check_flags("t_hit", 1'b1, 1'b0, 1'b0, 1'b1);
        check("t_hit_cc", cycle_count, 32'd19);
        tick();
        tick();
        check("t_frozen_cc", cycle_count, 32'd19);

        // Pass on the timeout edge takes precedence
        do_reset();
        for (int i = 0; i < 19; i++) tick();
        store(32'd216, 32'd4140);
        check_flags("t_pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t_pass_cc", cycle_count, 32'd19);

        // History wrap with six legal stores
        do_reset();
        for (int i = 0; i < 6; i++) store(32'(i * 4), 32'(i * 4 + 1));
        check_flags("w", 1'b0, 1'b0, 1'b0, 1'b0);
        check("w_hv", {29'd0, hist_valid}, 32'd4);
        check("w_sc", {16'd0, store_count}, 32'd6);
        check("w_cc", cycle_count, 32'd6);
        check_hist("w_h0", 2'd0, 32'd20, 32'd21);
        check_hist("w_h1", 2'd1, 32'd16, 32'd17);
        check_hist("w_h2", 2'd2, 32'd12, 32'd13);
        check_hist("w_h3", 2'd3, 32'd8, 32'd9);

        // Reset concurrent with a store discards it
        do_reset();
        store(32'd4, 32'd1);
        store(32'd8, 32'd2);
        store(32'd12, 32'd3);
        check("mr_pre_sc", {16'd0, store_count}, 32'd3);
        reset     = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'd216;
        WriteData = 32'd4140;
        tick();
        reset    = 1'b1;
        MemWrite = 1'b0;
        check_flags("mr", 1'b0, 1'b0, 1'b0, 1'b0);
        check("mr_sc", {16'd0, store_count}, 32'd0);
        check("mr_cc", cycle_count, 32'd0);
        check("mr_hv", {29'd0, hist_valid}, 32'd0);
        check_hist("mr_h0", 2'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
